// File: rtl/uart_operand_rx_pkg.sv
// Shared definitions for the UART operand receiver: ASCII constants, RX states
// and the hex-digit decoder used by the operand assembler.
package uart_operand_rx_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
    } hex_nib_t;

    function automatic hex_nib_t hex_to_nibble(input logic [7:0] c);
        hex_nib_t r;
        r.valid = 1'b1;
        r.nib   = '0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.nib = c[3:0];
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
            r.nib = c[3:0] + 4'd9;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_operand_rx_if.sv
// Operand/byte result bus of the UART operand receiver plus its clear request.
interface uart_operand_rx_if;

    logic        clear;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [63:0] opnd;
    logic        opnd_valid;
    logic [4:0]  digit_cnt;
    logic        hex_err;
    logic        ovf;

    modport master (
        input  clear,
        output rx_data, rx_valid, frame_err, opnd, opnd_valid, digit_cnt, hex_err, ovf
    );

    modport slave (
        output clear,
        input  rx_data, rx_valid, frame_err, opnd, opnd_valid, digit_cnt, hex_err, ovf
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, oversampling tick divider and RX FSM.
module uart_rx_byte
    import uart_operand_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW      = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] div_q, div_d;
    rx_state_e     state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    b_q, b_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          tick;
    logic          rxd_s;

    assign rxd_s = sync_q[1];
    assign tick  = (div_q == DW'(DIV - 1));
    assign div_d = tick ? '0 : div_q + DW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '1;
            div_q   <= '0;
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rxd_i};
            div_q   <= div_d;
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        b_d = '0;
                        state_d = rxd_s ? IDLE : DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        shift_d = {rxd_s, shift_q[7:1]};
                        s_d     = '0;
                        b_d     = b_q + 3'd1;
                        if (b_q == 3'd7) state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (rxd_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            BREAK: begin
                // A held-low line stays here so it cannot look like new start bits
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_operand_rx.sv
// UART operand entry: received ASCII hex digits build a 64-bit operand that is
// committed on carriage return.
module uart_operand_rx
    import uart_operand_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              UART_RXD,
    uart_operand_rx_if.master bus
);

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [63:0] opnd_q, opnd_d;
    logic        opnd_valid_q, opnd_valid_d;
    logic        hex_err_q, hex_err_d;
    hex_nib_t    hn;

    uart_rx_byte #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd_i      (UART_RXD),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err)
    );

    assign hn = hex_to_nibble(rx_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            opnd_q       <= '0;
            opnd_valid_q <= 1'b0;
            hex_err_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            opnd_q       <= opnd_d;
            opnd_valid_q <= opnd_valid_d;
            hex_err_q    <= hex_err_d;
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        opnd_d       = opnd_q;
        opnd_valid_d = 1'b0;
        hex_err_d    = 1'b0;
        if (bus.clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (rx_valid) begin
            if (hn.valid) begin
                // Shifting out the top nibble keeps the most recent 16 digits on overflow
                acc_d = {acc_q[59:0], hn.nib};
                if (cnt_q == 5'd16) ovf_d = 1'b1;
                else                cnt_d = cnt_q + 5'd1;
            end else if (rx_data == CHAR_CR) begin
                if (cnt_q != '0) begin
                    opnd_d       = acc_q;
                    opnd_valid_d = 1'b1;
                    acc_d        = '0;
                    cnt_d        = '0;
                    ovf_d        = 1'b0;
                end
            end else if (rx_data != CHAR_LF && rx_data != CHAR_SP) begin
                hex_err_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end
        end
    end

    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.frame_err  = frame_err;
    assign bus.opnd       = opnd_q;
    assign bus.opnd_valid = opnd_valid_q;
    assign bus.digit_cnt  = cnt_q;
    assign bus.hex_err    = hex_err_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_uart_operand_rx.sv
// Self-checking bench for uart_operand_rx: directed cases plus random character
// streams at randomized baud mismatch, compared against a digit-queue model.
module tb_uart_operand_rx;

    localparam int unsigned CLK_FREQ = 7372800;
    localparam int unsigned BAUD     = 115200;
    localparam int          BIT_CLKS = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;

    uart_operand_rx_if bus();

    uart_operand_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .UART_RXD(rxd),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters observed on the DUT outputs
    int mon_rxv = 0, mon_fe = 0, mon_ov = 0, mon_he = 0;
    always @(negedge clk) begin
        if (bus.rx_valid)   mon_rxv <= mon_rxv + 1;
        if (bus.frame_err)  mon_fe  <= mon_fe + 1;
        if (bus.opnd_valid) mon_ov  <= mon_ov + 1;
        if (bus.hex_err)    mon_he  <= mon_he + 1;
    end

    // Reference model state
    logic [3:0]  m_digits[$];
    logic [7:0]  m_rxdata = '0;
    logic [63:0] m_opnd   = '0;
    logic        m_ovf    = 1'b0;
    int e_rxv = 0, e_fe = 0, e_ov = 0, e_he = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int hex_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] c, input logic clr);
        int v;
        logic [63:0] val;
        e_rxv++;
        m_rxdata = c;
        v = hex_val(c);
        if (clr) begin
            m_digits.delete();
            m_ovf = 1'b0;
        end else if (v >= 0) begin
            m_digits.push_back(4'(v));
            if (m_digits.size() > 16) begin
                void'(m_digits.pop_front());
                m_ovf = 1'b1;
            end
        end else if (c == 8'h0D) begin
            if (m_digits.size() > 0) begin
                val = '0;
                foreach (m_digits[i]) val = val * 16 + 64'(m_digits[i]);
                m_opnd = val;
                e_ov++;
                m_digits.delete();
                m_ovf = 1'b0;
            end
        end else if (c != 8'h0A && c != 8'h20) begin
            e_he++;
            m_digits.delete();
            m_ovf = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_digits.delete();
        m_rxdata = '0;
        m_opnd   = '0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, " rx_valid#"},   64'(mon_rxv), 64'(e_rxv));
        check_eq({tag, " frame_err#"},  64'(mon_fe),  64'(e_fe));
        check_eq({tag, " opnd_valid#"}, 64'(mon_ov),  64'(e_ov));
        check_eq({tag, " hex_err#"},    64'(mon_he),  64'(e_he));
        check_eq({tag, " rx_data"},     64'(bus.rx_data), 64'(m_rxdata));
        check_eq({tag, " opnd"},        bus.opnd, m_opnd);
        check_eq({tag, " digit_cnt"},   64'(bus.digit_cnt), 64'(m_digits.size()));
        check_eq({tag, " ovf"},         64'(bus.ovf), 64'(m_ovf));
    endtask

    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_val);
        rxd = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bc) @(negedge clk);
        end
        rxd = stop_val;
        repeat (bc) @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] c, input int bc, input logic clr);
        bus.clear = clr;
        send_byte(c, bc, 1'b1);
        repeat (8) @(negedge clk);
        bus.clear = 1'b0;
        model_byte(c, clr);
        check_all($sformatf("byte %02h", c));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], BIT_CLKS, 1'b0);
    endtask

    initial begin
        string pool;
        int r;
        int bc;
        logic [7:0] c;
        pool = "0123456789abcdefABCDEF";
        bus.clear = 1'b0;

        repeat (5) @(negedge clk);
        check_eq("reset pulses", 64'({bus.rx_valid, bus.frame_err, bus.opnd_valid, bus.hex_err}), 64'(0));
        check_all("reset");
        rst = 1'b1;
        repeat (20) @(negedge clk);

        send_char(8'hA5, BIT_CLKS, 1'b0);
        check_eq("A5 rx_data", 64'(bus.rx_data), 64'h A5);

        send_str("1234abcd");
        send_char(8'h0D, BIT_CLKS, 1'b0);
        check_eq("1234abcd opnd", bus.opnd, 64'h0000_0000_1234_ABCD);

        send_str("123456789ABCDEF01");
        check_eq("17dig ovf", 64'(bus.ovf), 64'd1);
        send_char(8'h0D, BIT_CLKS, 1'b0);
        check_eq("17dig opnd", bus.opnd, 64'h2345_6789_ABCD_EF01);

        send_str("12G");
        check_eq("12G digit_cnt", 64'(bus.digit_cnt), 64'd0);
        send_str("5");
        send_char(8'h0D, BIT_CLKS, 1'b0);
        check_eq("5 opnd", bus.opnd, 64'h5);

        // Bad stop bit, then line held low for 20 bit times
        send_byte(8'h55, BIT_CLKS, 1'b0);
        repeat (20 * BIT_CLKS) @(negedge clk);
        e_fe++;
        check_all("break");
        rxd = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        send_char(8'h41, BIT_CLKS, 1'b0);
        check_eq("post-break rx_data", 64'(bus.rx_data), 64'h41);

        rxd = 1'b0;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check_all("glitch");

        send_str("12");
        send_char(8'h33, BIT_CLKS, 1'b1);
        send_str("4");
        send_char(8'h0D, BIT_CLKS, 1'b0);
        check_eq("clear opnd", bus.opnd, 64'h4);

        // Reset in the middle of a frame
        send_str("9");
        rxd = 1'b0;
        repeat (4 * BIT_CLKS) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (100) @(negedge clk);
        check_all("mid-rst");
        send_str("7");
        send_char(8'h0D, BIT_CLKS, 1'b0);
        check_eq("7 opnd", bus.opnd, 64'h7);
        send_char(8'h0D, BIT_CLKS, 1'b0);
        check_eq("lone CR opnd_valid#", 64'(mon_ov), 64'(e_ov));

        for (int n = 0; n < 50; n++) begin
            bc = $urandom_range(62, 66);
            r  = $urandom_range(0, 11);
            if (r <= 6)       c = pool[$urandom_range(0, pool.len() - 1)];
            else if (r == 7)  c = 8'h0D;
            else if (r == 8)  c = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h20;
            else              c = 8'($urandom_range(0, 255));
            send_char(c, bc, (r == 11) ? 1'b1 : 1'b0);
            if (r == 10) begin
                rxd = 1'b0;
                repeat (10) @(negedge clk);
                rxd = 1'b1;
                repeat (100) @(negedge clk);
                check_all("rand glitch");
            end
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
